// File: rtl/exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctrl_pkg
//   Shared definitions for the execute-stage controller and its neighbours.
//   - exec_ctrl_state_e : controller FSM encoding
//   - OP_* constants    : control-flow opcodes shared with decode/executor
//   - is_control_flow() : true for opcodes that can redirect fetch
// ---------------------------------------------------------------------------
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        OUT   = 2'b10,
        FLUSH = 2'b11
    } exec_ctrl_state_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Decode-side helper: ops whose outcome may produce a redirect.
    function automatic logic is_control_flow(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/flush_timer.sv
// ---------------------------------------------------------------------------
// flush_timer
//   Down-counter that times the pipeline flush window after a redirect.
//   Ports:
//     clk    in  clock
//     reset  in  asynchronous, active-low
//     load   in  load the counter with FLUSH_CYCLES
//     active out counter is non-zero (flush window open)
//     last   out counter equals 1 (final flush cycle)
// ---------------------------------------------------------------------------
module flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic active,
    output logic last
);

    localparam int W = $clog2(FLUSH_CYCLES + 1);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so that
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(FLUSH_CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign active = (count != '0);
    assign last   = (count == W'(1));

endmodule

// File: rtl/execute_stage_controller.sv
// ---------------------------------------------------------------------------
// execute_stage_controller
//   Sequences one decoded op at a time through the executor, holds the result
//   for writeback under backpressure, and on a taken jump/branch issues a
//   one-cycle fetch redirect followed by a fixed-length flush.
//   Ports:
//     clk, reset                 clock; asynchronous active-low reset
//     id_valid/id_ready/id_pc    op handshake from decode
//     exec_enable                execute_enable to executor (high in EXEC)
//     exec_done/jump/target/result  executor completion and outcome
//     wb_valid/wb_ready          result handshake to writeback/memory
//     wb_result/wb_pc            captured ALU result and op PC
//     redirect_valid/redirect_pc one-cycle fetch redirect, target bit 0 cleared
//     flush                      squash younger ops in fetch/decode
//     redirect_count             saturating count of taken redirects
// ---------------------------------------------------------------------------
module execute_stage_controller
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    output logic             exec_enable,
    input  logic             exec_done,
    input  logic             exec_jump,
    input  logic [XLEN-1:0]  exec_target,
    input  logic [XLEN-1:0]  exec_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  wb_pc,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [XLEN-1:0]  ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    exec_ctrl_state_e state;
    logic [XLEN-1:0]  pc_q;      // PC of the op currently executing
    logic [XLEN-1:0]  target_q;  // aligned jump target awaiting handshake
    logic             jump_q;
    logic             timer_active;
    logic             timer_last;
    logic             wb_fire;

    assign wb_fire = (state == OUT) && wb_ready;

    // Combinational on wb_ready so a non-jump op can hand off and accept the
    // next op in the same cycle, giving one op every two cycles.
    assign id_ready = (state == IDLE) || (wb_fire && !jump_q);

    flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (wb_fire && jump_q),
        .active (timer_active),
        .last   (timer_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            exec_enable    <= 1'b0;
            wb_valid       <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            pc_q           <= '0;
            target_q       <= '0;
            jump_q         <= 1'b0;
            wb_result      <= '0;
            wb_pc          <= '0;
            redirect_pc    <= '0;
            redirect_count <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (id_valid) begin
                        pc_q        <= id_pc;
                        exec_enable <= 1'b1;
                        state       <= EXEC;
                    end
                end

                EXEC: begin
                    if (exec_done) begin
                        wb_result   <= exec_result;
                        wb_pc       <= pc_q;
                        jump_q      <= exec_jump;
                        target_q    <= exec_target & ALIGN_MASK;
                        exec_enable <= 1'b0;
                        wb_valid    <= 1'b1;
                        state       <= OUT;
                    end
                end

                OUT: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (jump_q) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= target_q;
                            flush          <= 1'b1;
                            if (redirect_count != CNT_MAX) begin
                                redirect_count <= redirect_count + CNT_W'(1);
                            end
                            state <= FLUSH;
                        end else if (id_valid) begin
                            pc_q        <= id_pc;
                            exec_enable <= 1'b1;
                            state       <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                FLUSH: begin
                    // Ops offered during flush are squashed: id_ready stays low
                    // and nothing is latched.
                    if (timer_last || !timer_active) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    exec_enable <= 1'b0;
                    wb_valid    <= 1'b0;
                    flush       <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_execute_stage_controller
//   Table-driven per-cycle vectors for the basic, backpressure, back-to-back
//   and jump flows, followed by hand-written reset-mid-EXEC and counter
//   saturation sequences.
// ---------------------------------------------------------------------------
module tb_execute_stage_controller;

    localparam int XLEN  = 64;
    localparam int FLUSH = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic             exec_enable;
    logic             exec_done;
    logic             exec_jump;
    logic [XLEN-1:0]  exec_target;
    logic [XLEN-1:0]  exec_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [XLEN-1:0]  wb_result;
    logic [XLEN-1:0]  wb_pc;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] redirect_count;

    int n_cmp  = 0;
    int n_fail = 0;

    execute_stage_controller #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .exec_enable    (exec_enable),
        .exec_done      (exec_done),
        .exec_jump      (exec_jump),
        .exec_target    (exec_target),
        .exec_result    (exec_result),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_result      (wb_result),
        .wb_pc          (wb_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string           name;
        logic            iv;
        logic [XLEN-1:0] ipc;
        logic            done;
        logic            jmp;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] res;
        logic            wbr;
        logic            e_rdy;
        logic            e_en;
        logic            e_wbv;
        logic [XLEN-1:0] e_res;
        logic [XLEN-1:0] e_pc;
        logic            e_rv;
        logic [XLEN-1:0] e_rpc;
        logic            e_fl;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic iv, input logic [XLEN-1:0] ipc,
                       input logic done, input logic jmp, input logic [XLEN-1:0] tgt,
                       input logic [XLEN-1:0] res, input logic wbr,
                       input logic e_rdy, input logic e_en, input logic e_wbv,
                       input logic [XLEN-1:0] e_res, input logic [XLEN-1:0] e_pc,
                       input logic e_rv, input logic [XLEN-1:0] e_rpc,
                       input logic e_fl, input logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.name = nm;   v.iv = iv;     v.ipc = ipc;   v.done = done; v.jmp = jmp;
        v.tgt = tgt;   v.res = res;   v.wbr = wbr;
        v.e_rdy = e_rdy; v.e_en = e_en; v.e_wbv = e_wbv; v.e_res = e_res;
        v.e_pc = e_pc; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [XLEN-1:0] ipc, input logic done,
                         input logic jmp, input logic [XLEN-1:0] tgt,
                         input logic [XLEN-1:0] res, input logic wbr);
        id_valid    = iv;
        id_pc       = ipc;
        exec_done   = done;
        exec_jump   = jmp;
        exec_target = tgt;
        exec_result = res;
        wb_ready    = wbr;
    endtask

    task automatic check_all(input string nm, input logic rdy, input logic en,
                             input logic wbv, input logic [XLEN-1:0] res,
                             input logic [XLEN-1:0] pc, input logic rv,
                             input logic [XLEN-1:0] rpc, input logic fl,
                             input logic [CNT_W-1:0] cnt);
        check({nm, ".id_ready"},       XLEN'(id_ready),       XLEN'(rdy));
        check({nm, ".exec_enable"},    XLEN'(exec_enable),    XLEN'(en));
        check({nm, ".wb_valid"},       XLEN'(wb_valid),       XLEN'(wbv));
        check({nm, ".wb_result"},      wb_result,             res);
        check({nm, ".wb_pc"},          wb_pc,                 pc);
        check({nm, ".redirect_valid"}, XLEN'(redirect_valid), XLEN'(rv));
        check({nm, ".redirect_pc"},    redirect_pc,           rpc);
        check({nm, ".flush"},          XLEN'(flush),          XLEN'(fl));
        check({nm, ".redirect_count"}, XLEN'(redirect_count), XLEN'(cnt));
    endtask

    // One complete taken-jump transaction starting and ending in IDLE.
    task automatic do_jump(input logic [XLEN-1:0] tgt, input logic [CNT_W-1:0] exp_cnt,
                           input string nm);
        @(negedge clk); drive(1'b1, 64'h8000, 1'b0, 1'b0, '0, '0, 1'b0);   // IDLE accept
        @(negedge clk); drive(1'b0, '0, 1'b1, 1'b1, tgt, 64'h1, 1'b0);     // EXEC done
        @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);         // OUT handshake
        @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);         // FLUSH 0
        #1;
        check({nm, ".redirect_valid"}, XLEN'(redirect_valid), XLEN'(1));
        check({nm, ".redirect_pc"}, redirect_pc, tgt & ~64'h1);
        @(negedge clk);                                                     // FLUSH 1
        @(negedge clk);                                                     // IDLE
        #1;
        check({nm, ".flush_done"}, XLEN'(flush), XLEN'(0));
        check({nm, ".redirect_count"}, XLEN'(redirect_count), XLEN'(exp_cnt));
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Columns: name | iv ipc done jmp tgt res wbr | rdy en wbv res pc rv rpc fl cnt
        // Basic op, exec_done same cycle as exec_enable, then OUT held for 3 cycles.
        add("t2_accept",   1, 64'h1000, 0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h0,    64'h0,    0, 64'h0,    0, 0);
        add("t2_exec",     0, 64'h0,    1, 0, 64'h5555, 64'h2A,   0,  0, 1, 0, 64'h0,    64'h0,    0, 64'h0,    0, 0);
        add("t3_stall0",   0, 64'h0,    1, 0, 64'h0,    64'hFF,   0,  0, 0, 1, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t3_stall1",   1, 64'h9999, 0, 0, 64'h0,    64'h0,    0,  0, 0, 1, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t3_stall2",   1, 64'h9999, 1, 1, 64'h0,    64'hEE,   0,  0, 0, 1, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t3_release",  0, 64'h0,    0, 0, 64'h0,    64'h0,    1,  1, 0, 1, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t2_idle",     0, 64'h0,    0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        // Two non-jump ops back-to-back; second accepted during first's OUT.
        add("t5_acc1",     1, 64'h1100, 0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t5_exe1",     0, 64'h0,    1, 0, 64'h0,    64'h11,   0,  0, 1, 0, 64'h2A,   64'h1000, 0, 64'h0,    0, 0);
        add("t5_out1",     1, 64'h1200, 0, 0, 64'h0,    64'h0,    1,  1, 0, 1, 64'h11,   64'h1100, 0, 64'h0,    0, 0);
        add("t5_exe2",     0, 64'h0,    1, 0, 64'h0,    64'h22,   1,  0, 1, 0, 64'h11,   64'h1100, 0, 64'h0,    0, 0);
        add("t5_out2",     0, 64'h0,    0, 0, 64'h0,    64'h0,    1,  1, 0, 1, 64'h22,   64'h1200, 0, 64'h0,    0, 0);
        add("t5_idle",     0, 64'h0,    0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h22,   64'h1200, 0, 64'h0,    0, 0);
        // Taken JALR to odd target, with one EXEC wait cycle and one OUT stall.
        add("t4_acc",      1, 64'h1300, 0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h22,   64'h1200, 0, 64'h0,    0, 0);
        add("t4_wait",     0, 64'h0,    0, 1, 64'h0,    64'h0,    0,  0, 1, 0, 64'h22,   64'h1200, 0, 64'h0,    0, 0);
        add("t4_exec",     0, 64'h0,    1, 1, 64'h2003, 64'h1304, 0,  0, 1, 0, 64'h22,   64'h1200, 0, 64'h0,    0, 0);
        add("t4_out_hold", 1, 64'h4000, 0, 0, 64'h0,    64'h0,    0,  0, 0, 1, 64'h1304, 64'h1300, 0, 64'h0,    0, 0);
        add("t4_out_go",   1, 64'h4000, 0, 0, 64'h0,    64'h0,    1,  0, 0, 1, 64'h1304, 64'h1300, 0, 64'h0,    0, 0);
        add("t4_flush0",   1, 64'h4000, 0, 0, 64'h0,    64'h0,    1,  0, 0, 0, 64'h1304, 64'h1300, 1, 64'h2002, 1, 1);
        add("t4_flush1",   1, 64'h4000, 1, 0, 64'h0,    64'h0,    1,  0, 0, 0, 64'h1304, 64'h1300, 0, 64'h2002, 1, 1);
        add("t4_idle",     0, 64'h0,    0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h1304, 64'h1300, 0, 64'h2002, 0, 1);
        add("t4_idle2",    0, 64'h0,    0, 0, 64'h0,    64'h0,    0,  1, 0, 0, 64'h1304, 64'h1300, 0, 64'h2002, 0, 1);

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check_all("reset", 1, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ipc, vecs[i].done, vecs[i].jmp,
                  vecs[i].tgt, vecs[i].res, vecs[i].wbr);
            #1;
            check_all(vecs[i].name, vecs[i].e_rdy, vecs[i].e_en, vecs[i].e_wbv,
                      vecs[i].e_res, vecs[i].e_pc, vecs[i].e_rv, vecs[i].e_rpc,
                      vecs[i].e_fl, vecs[i].e_cnt);
        end

        // Reset asserted in the third cycle of an op, coinciding with exec_done.
        @(negedge clk); drive(1'b1, 64'h5000, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        check("t1_in_exec.exec_enable", XLEN'(exec_enable), XLEN'(1));
        @(negedge clk);
        #2;
        drive(1'b0, '0, 1'b1, 1'b1, 64'h3001, 64'h77, 1'b1);
        reset = 1'b0;
        #1;
        check_all("t1_async", 1, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0);
        @(negedge clk);
        #1;
        check_all("t1_held", 1, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("t1_after.wb_valid",    XLEN'(wb_valid),    XLEN'(0));
            check("t1_after.exec_enable", XLEN'(exec_enable), XLEN'(0));
            check("t1_after.id_ready",    XLEN'(id_ready),    XLEN'(1));
        end

        // Seventeen taken jumps: the 4-bit counter must stop at 0xF.
        for (int j = 0; j < 17; j++) begin
            do_jump(64'h101 + 64'(j) * 64'h10,
                    (j + 1 > 15) ? CNT_W'(15) : CNT_W'(j + 1),
                    $sformatf("t6_jump%0d", j));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
